// File: rtl/spi_bitrev_slave_pkg.sv
// Shared SPI slave definitions: FSM state encodings and SPI mode constants,
// intended for reuse by other oversampled SPI peripherals.
package spi_bitrev_slave_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RX      = 2'd1;
   localparam logic [1:0] ST_TX_WAIT = 2'd2;
   localparam logic [1:0] ST_TX      = 2'd3;

   localparam bit CPOL_IDLE_LOW       = 1'b0;
   localparam bit CPHA_SAMPLE_LEADING = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises sck/ss/mosi into the system clock domain with equal depth and
// turns synced sck transitions into mode-aware sample/shift strobes.
module spi_sync_edge
   import spi_bitrev_slave_pkg::*;
#(
   parameter bit CPOL        = CPOL_IDLE_LOW,
   parameter bit CPHA        = CPHA_SAMPLE_LEADING,
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   output logic ss_s,
   output logic mosi_s,
   output logic sample_pulse,
   output logic shift_pulse
);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_last;
   logic                   sck_now;
   logic                   leading;
   logic                   trailing;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sck_sync  <= {SYNC_STAGES{CPOL}};
         ss_sync   <= '1;
         mosi_sync <= '1;
         sck_last  <= CPOL;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_last  <= sck_sync[SYNC_STAGES-1];
      end
   end

   // mosi shares the sck depth, so mosi_s is the bit present at the detected edge
   assign sck_now      = sck_sync[SYNC_STAGES-1];
   assign ss_s         = ss_sync[SYNC_STAGES-1];
   assign mosi_s       = mosi_sync[SYNC_STAGES-1];
   assign leading      = (sck_last == CPOL) && (sck_now != CPOL);
   assign trailing     = (sck_last != CPOL) && (sck_now == CPOL);
   assign sample_pulse = (CPHA == CPHA_SAMPLE_LEADING) ? leading : trailing;
   assign shift_pulse  = (CPHA == CPHA_SAMPLE_LEADING) ? trailing : leading;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives a WIDTH-bit word and returns it bit-reversed in the
// following WIDTH sck cycles of the same chip-select window.
module spi_bitrev_slave
   import spi_bitrev_slave_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = CPOL_IDLE_LOW,
   parameter bit CPHA        = CPHA_SAMPLE_LEADING,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sck,
   input  logic             ss,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_done,
   output logic             abort
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             ss_s;
   logic             mosi_s;
   logic             sample_pulse;
   logic             shift_pulse;
   logic [1:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] tx_word;
   logic [WIDTH-1:0] word_next;

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
      return r;
   endfunction

   spi_sync_edge #(
      .CPOL        (CPOL),
      .CPHA        (CPHA),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clock        (clock),
      .reset        (reset),
      .sck          (sck),
      .ss           (ss),
      .mosi         (mosi),
      .ss_s         (ss_s),
      .mosi_s       (mosi_s),
      .sample_pulse (sample_pulse),
      .shift_pulse  (shift_pulse)
   );

   assign word_next = {shreg[WIDTH-2:0], mosi_s};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx_word    <= '0;
         miso       <= 1'b1;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_done <= 1'b0;
         abort      <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         frame_done <= 1'b0;
         abort      <= 1'b0;
         // ss deassertion outranks any sck edge seen in the same clock
         if (state != ST_IDLE && ss_s) begin
            state   <= ST_IDLE;
            miso    <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            abort   <= (state != ST_RX) || (bit_cnt != '0);
         end else begin
            case (state)
               ST_IDLE: begin
                  miso <= 1'b1;
                  if (!ss_s) begin
                     state   <= ST_RX;
                     bit_cnt <= '0;
                  end
               end
               ST_RX: begin
                  if (sample_pulse) begin
                     if (bit_cnt == LAST) begin
                        rx_data  <= word_next;
                        rx_valid <= 1'b1;
                        tx_word  <= bitrev(word_next);
                        shreg    <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_TX_WAIT;
                     end else begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (shift_pulse) begin
                     miso <= 1'b1;
                  end
               end
               ST_TX_WAIT: begin
                  if (shift_pulse) begin
                     miso    <= tx_word[WIDTH-1];
                     tx_word <= {tx_word[WIDTH-2:0], 1'b0};
                     state   <= ST_TX;
                  end
               end
               ST_TX: begin
                  if (sample_pulse) begin
                     if (bit_cnt == LAST) begin
                        frame_done <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= ST_RX;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (shift_pulse) begin
                     miso    <= tx_word[WIDTH-1];
                     tx_word <= {tx_word[WIDTH-2:0], 1'b0};
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave: four instances (modes 0..3) driven by a
// behavioural SPI master and checked against a bit-reversal reference model.
`timescale 1ns/1ps
module tb_spi_bitrev_slave;

   localparam int HALF = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] sck_v;
   logic [3:0] ss_v;
   logic [3:0] mosi_v;
   wire  [3:0] miso_v;
   wire  [3:0] rxv_v;
   wire  [3:0] fd_v;
   wire  [3:0] ab_v;
   wire  [7:0] rx8_0, rx8_1, rx8_2;
   wire  [15:0] rx16_3;

   int rxv_cnt[4];
   int fd_cnt[4];
   int ab_cnt[4];
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          d;
      logic [15:0] word;
      logic [15:0] reply;
   } vec_t;

   vec_t tbl[6];

   always #5 clock = ~clock;

   spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
      .clock(clock), .reset(reset), .sck(sck_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]),
      .miso(miso_v[0]), .rx_data(rx8_0), .rx_valid(rxv_v[0]), .frame_done(fd_v[0]), .abort(ab_v[0]));
   spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_m1 (
      .clock(clock), .reset(reset), .sck(sck_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]),
      .miso(miso_v[1]), .rx_data(rx8_1), .rx_valid(rxv_v[1]), .frame_done(fd_v[1]), .abort(ab_v[1]));
   spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) u_m2 (
      .clock(clock), .reset(reset), .sck(sck_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]),
      .miso(miso_v[2]), .rx_data(rx8_2), .rx_valid(rxv_v[2]), .frame_done(fd_v[2]), .abort(ab_v[2]));
   spi_bitrev_slave #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
      .clock(clock), .reset(reset), .sck(sck_v[3]), .ss(ss_v[3]), .mosi(mosi_v[3]),
      .miso(miso_v[3]), .rx_data(rx16_3), .rx_valid(rxv_v[3]), .frame_done(fd_v[3]), .abort(ab_v[3]));

   always @(posedge clock) begin
      for (int d = 0; d < 4; d++) begin
         if (rxv_v[d]) rxv_cnt[d] <= rxv_cnt[d] + 1;
         if (fd_v[d])  fd_cnt[d]  <= fd_cnt[d] + 1;
         if (ab_v[d])  ab_cnt[d]  <= ab_cnt[d] + 1;
      end
   end

   function automatic bit cpol_of(int d);
      return (d >= 2);
   endfunction

   function automatic bit cpha_of(int d);
      return (d == 1) || (d == 3);
   endfunction

   function automatic int width_of(int d);
      return (d == 3) ? 16 : 8;
   endfunction

   function automatic logic [15:0] mask_of(int w);
      return (w == 16) ? 16'hFFFF : 16'((1 << w) - 1);
   endfunction

   function automatic logic [15:0] rx_of(int d);
      case (d)
         0:       return {8'h00, rx8_0};
         1:       return {8'h00, rx8_1};
         2:       return {8'h00, rx8_2};
         default: return rx16_3;
      endcase
   endfunction

   // Reference: the bit of weight 2^i moves to weight 2^(n-1-i)
   function automatic logic [15:0] rev_ref(logic [15:0] w, int n);
      int acc = 0;
      for (int i = 0; i < n; i++)
         if (w[i]) acc = acc + (1 << (n - 1 - i));
      return 16'(acc);
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic ss_begin(int d);
      ss_v[d] = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic ss_end(int d);
      wait_clk(HALF);
      ss_v[d] = 1'b1;
      wait_clk(HALF);
   endtask

   // Clocks nb bits MSB first from din[nb-1:0]; miso captured at the master sample edge
   task automatic shift_bits(int d, int nb, logic [15:0] din, output logic [15:0] dout);
      dout = '0;
      for (int i = nb - 1; i >= 0; i--) begin
         if (!cpha_of(d)) begin
            mosi_v[d] = din[i];
            wait_clk(HALF);
            dout[i]  = miso_v[d];
            sck_v[d] = ~cpol_of(d);
            wait_clk(HALF);
            sck_v[d] = cpol_of(d);
         end else begin
            sck_v[d]  = ~cpol_of(d);
            mosi_v[d] = din[i];
            wait_clk(HALF);
            dout[i]  = miso_v[d];
            sck_v[d] = cpol_of(d);
            wait_clk(HALF);
         end
      end
   endtask

   task automatic full_frame(int d, logic [15:0] word, logic [15:0] exp_reply);
      int          w;
      int          r0, f0, a0;
      logic [15:0] rxo, rep;
      w  = width_of(d);
      r0 = rxv_cnt[d];
      f0 = fd_cnt[d];
      a0 = ab_cnt[d];
      ss_begin(d);
      shift_bits(d, w, word, rxo);
      check($sformatf("m%0d miso during rx", d), rxo, mask_of(w));
      check($sformatf("m%0d rx_data %0h", d, word), rx_of(d), word & mask_of(w));
      check($sformatf("m%0d rx_valid pulses", d), 16'(rxv_cnt[d] - r0), 16'd1);
      shift_bits(d, w, 16'h0000, rep);
      check($sformatf("m%0d reply to %0h", d, word), rep, exp_reply);
      ss_end(d);
      check($sformatf("m%0d frame_done pulses", d), 16'(fd_cnt[d] - f0), 16'd1);
      check($sformatf("m%0d abort pulses", d), 16'(ab_cnt[d] - a0), 16'd0);
      check($sformatf("m%0d miso idle after", d), 16'(miso_v[d]), 16'd1);
   endtask

   task automatic back_to_back(int d);
      int          r0, f0, a0;
      logic [15:0] tmp, rep;
      r0 = rxv_cnt[d];
      f0 = fd_cnt[d];
      a0 = ab_cnt[d];
      ss_begin(d);
      shift_bits(d, 8, 16'h0001, tmp);
      check($sformatf("m%0d b2b rx0", d), rx_of(d), 16'h0001);
      shift_bits(d, 8, 16'h0000, rep);
      check($sformatf("m%0d b2b reply0", d), rep, 16'h0080);
      shift_bits(d, 8, 16'h0080, tmp);
      check($sformatf("m%0d b2b miso during rx1", d), tmp, 16'h00FF);
      check($sformatf("m%0d b2b rx1", d), rx_of(d), 16'h0080);
      shift_bits(d, 8, 16'h0000, rep);
      check($sformatf("m%0d b2b reply1", d), rep, 16'h0001);
      ss_end(d);
      check($sformatf("m%0d b2b rx_valid", d), 16'(rxv_cnt[d] - r0), 16'd2);
      check($sformatf("m%0d b2b frame_done", d), 16'(fd_cnt[d] - f0), 16'd2);
      check($sformatf("m%0d b2b abort", d), 16'(ab_cnt[d] - a0), 16'd0);
   endtask

   initial begin
      logic [15:0] tmp, word;
      int          r0, f0, a0, bad;

      tbl[0] = '{0, 16'h0012, 16'h0048};
      tbl[1] = '{3, 16'h1234, 16'h2C48};
      tbl[2] = '{1, 16'h000B, 16'h00D0};
      tbl[3] = '{2, 16'h0001, 16'h0080};
      tbl[4] = '{2, 16'h00F0, 16'h000F};
      tbl[5] = '{3, 16'h8001, 16'h8001};

      reset = 1'b1;
      for (int d = 0; d < 4; d++) begin
         sck_v[d]  = cpol_of(d);
         ss_v[d]   = 1'b1;
         mosi_v[d] = 1'b1;
      end
      wait_clk(4);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("m%0d reset miso", d), 16'(miso_v[d]), 16'd1);
         check($sformatf("m%0d reset rx_data", d), rx_of(d), 16'h0000);
      end
      reset = 1'b0;
      wait_clk(4);
      check("idle pulses", 16'(rxv_v | fd_v | ab_v), 16'h0000);

      for (int t = 0; t < 6; t++)
         full_frame(tbl[t].d, tbl[t].word, tbl[t].reply);

      back_to_back(1);
      back_to_back(2);

      // Abort mid-RX
      r0 = rxv_cnt[0]; f0 = fd_cnt[0]; a0 = ab_cnt[0];
      ss_begin(0);
      shift_bits(0, 5, 16'h0015, tmp);
      ss_end(0);
      check("abort rx pulse", 16'(ab_cnt[0] - a0), 16'd1);
      check("abort rx no rx_valid", 16'(rxv_cnt[0] - r0), 16'd0);
      check("abort rx miso", 16'(miso_v[0]), 16'd1);

      // Abort mid-TX
      r0 = rxv_cnt[0]; f0 = fd_cnt[0]; a0 = ab_cnt[0];
      ss_begin(0);
      shift_bits(0, 8, 16'h005A, tmp);
      shift_bits(0, 3, 16'h0000, tmp);
      ss_end(0);
      check("abort tx pulse", 16'(ab_cnt[0] - a0), 16'd1);
      check("abort tx no frame_done", 16'(fd_cnt[0] - f0), 16'd0);
      check("abort tx rx_valid", 16'(rxv_cnt[0] - r0), 16'd1);
      check("abort tx miso", 16'(miso_v[0]), 16'd1);
      full_frame(0, 16'h00F0, 16'h000F);

      // Abort mid-RX in mode 3
      a0 = ab_cnt[3]; r0 = rxv_cnt[3];
      ss_begin(3);
      shift_bits(3, 5, 16'h0011, tmp);
      ss_end(3);
      check("m3 abort rx pulse", 16'(ab_cnt[3] - a0), 16'd1);
      check("m3 abort rx no rx_valid", 16'(rxv_cnt[3] - r0), 16'd0);

      // Asynchronous reset mid-TX: reply to 0xA5 has a 0 in its fourth bit
      ss_begin(0);
      shift_bits(0, 8, 16'h00A5, tmp);
      shift_bits(0, 3, 16'h0000, tmp);
      wait_clk(4);
      check("pre-reset miso", 16'(miso_v[0]), 16'd0);
      check("pre-reset rx_data", rx_of(0), 16'h00A5);
      a0 = ab_cnt[0];
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("async reset miso", 16'(miso_v[0]), 16'd1);
      check("async reset rx_data", rx_of(0), 16'h0000);
      check("async reset pulses", 16'({rxv_v[0], fd_v[0], ab_v[0]}), 16'd0);
      ss_v[0] = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(4);
      check("reset no abort", 16'(ab_cnt[0] - a0), 16'd0);
      full_frame(0, 16'h00C3, 16'h00C3);

      // sck toggling while deselected
      r0 = rxv_cnt[0] + rxv_cnt[3]; f0 = fd_cnt[0] + fd_cnt[3]; a0 = ab_cnt[0] + ab_cnt[3];
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         sck_v[0]  = ~sck_v[0];
         sck_v[3]  = ~sck_v[3];
         mosi_v[0] = 1'($urandom);
         mosi_v[3] = 1'($urandom);
         wait_clk(HALF);
         if (miso_v[0] !== 1'b1 || miso_v[3] !== 1'b1) bad++;
      end
      check("deselected miso", 16'(bad), 16'd0);
      check("deselected rx_valid", 16'(rxv_cnt[0] + rxv_cnt[3] - r0), 16'd0);
      check("deselected frame_done", 16'(fd_cnt[0] + fd_cnt[3] - f0), 16'd0);
      check("deselected abort", 16'(ab_cnt[0] + ab_cnt[3] - a0), 16'd0);

      // Randomised frames against the reference model
      for (int n = 0; n < 3; n++) begin
         for (int d = 0; d < 4; d++) begin
            word = 16'($urandom) & mask_of(width_of(d));
            full_frame(d, word, rev_ref(word, width_of(d)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
